chunked_serial_adder: RTL and testbench
=======================================

Name: chunked_serial_adder

Overview:
- Multi-cycle parametrised adder: computes sum = a + b + cin over WIDTH bits, CHUNK bits per clock.
- Successor to the single-bit full adder; trades latency for area.
- Valid/ready handshake on both sides; one operation in flight at a time.
- Sits in the datapath as a reusable arithmetic unit between producer and consumer stages.

Parameters:
- WIDTH, 8: operand and sum width in bits; must be at least 1.
- CHUNK, 2: bits added per CALC cycle; 1 <= CHUNK <= WIDTH, and WIDTH % CHUNK == 0 (elaboration-time assertion).
- Derived, not overridable: NCHUNK = WIDTH/CHUNK. Chunk index width is $clog2(NCHUNK), minimum 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a, b, cin are valid.
- in_ready  out  1  block can accept operands; equals (state==S_IDLE) && !rst.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- cin  in  1  carry-in.
- out_valid  out  1  sum/cout hold a completed result.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result bits, registered.
- cout  out  1  carry-out of bit WIDTH-1, registered.

Behaviour:
- Reset: state=S_IDLE; sum=0, cout=0, out_valid=0; chunk index=0; operand registers=0.
  - While rst is high, in_ready=0.
  - Reset mid-CALC or mid-DONE aborts the operation; no result is ever presented.
- FSM states: S_IDLE, S_CALC, S_DONE.
- S_IDLE:
  - in_valid && in_ready at an edge: latch a, b, cin; clear sum to 0; idx=0; carry register=cin; go to S_CALC.
  - in_valid without acceptance has no effect.
- S_CALC, one step per cycle:
  - Add a[idx*CHUNK +: CHUNK] + b[same slice] + carry.
  - Write the CHUNK-bit result into the same slice of sum; update carry; idx++.
  - When idx==NCHUNK-1 at the edge: write cout=final carry; go to S_DONE.
  - Inputs are ignored in this state; in_ready=0.
- S_DONE:
  - out_valid=1; sum and cout held stable.
  - out_valid && out_ready at an edge: go to S_IDLE, out_valid drops.
  - No operand is accepted on that same edge; next accept is earliest one cycle later.
- Latency: accept at edge E0 → out_valid high after edge E_NCHUNK (NCHUNK cycles).
  - Minimum issue interval: NCHUNK+2 cycles with out_ready tied high.
- CHUNK==WIDTH: single CALC cycle.
- Arithmetic:
  - Unsigned modulo 2^WIDTH; overflow beyond WIDTH reported only via cout.
  - Per-chunk add is CHUNK+1 bits wide.
- sum contents are defined (partially written) during S_CALC, but meaningful only when out_valid=1.

Optional Feature:
- Macro: CHUNKED_ADDER_OVF_EN.
- Defined:
  - Extra output port ovf (out, 1) = signed two's-complement overflow, i.e. carry into MSB XOR carry out of MSB.
  - Registered with cout; reset 0; valid under out_valid.
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Decomposition:
- Package chunked_adder_pkg holds typedef enum logic [1:0] state_t {S_IDLE, S_CALC, S_DONE}.
  - Width-dependent values stay in the module.
- Sub-module chunk_add: purely combinational, parameter CHUNK.
  - Inputs x, y, ci; outputs s, co.
  - Exposes carry-into-MSB for the overflow option.
  - Instantiated once; FSM, registers and slice muxing live in the top.

Test Plan:
- Reset (WIDTH=8, CHUNK=2): hold rst 3 cycles with in_valid=1.
  → in_ready=0, out_valid=0, sum=0, cout=0 throughout.
  → in_ready=1 the cycle after rst drops.
- Basic add: a=8'hFF, b=8'h01, cin=0, accepted at E0.
  → out_valid rises after E4, sum=8'h00, cout=1.
  → Repeat with a=8'h3C, b=8'h42, cin=1 → sum=8'h7F, cout=0.
- Backpressure: hold out_ready=0 for 6 cycles in S_DONE while driving in_valid=1 with new operands.
  → sum/cout stable, in_ready=0, new operands ignored.
  → After out_ready=1, next accept occurs one cycle later.
- Reset mid-operation: assert rst 2 cycles after accept.
  → out_valid never asserts, sum=0, state S_IDLE.
  → Next operation (8'h10 + 8'h20) yields sum=8'h30 normally.
- Exhaustive: WIDTH=4, CHUNK=1 (and CHUNK=4), all 512 combinations of a, b, cin.
  → {cout,sum} equals a+b+cin from a behavioural model; latency 4 (resp. 1) cycles each.
- Overflow (CHUNKED_ADDER_OVF_EN, WIDTH=8):
  → 8'h7F+8'h01 → ovf=1, cout=0.
  → 8'h80+8'hFF → ovf=1, cout=1.
  → 8'h01+8'h01 → ovf=0.

Source files
------------

// File: rtl/chunked_serial_adder_pkg.sv
// Shared FSM state encoding for the chunked serial adder.
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/chunked_serial_adder_chunk_add.sv
// Combinational CHUNK-bit adder slice with carry in/out.
// With CHUNKED_ADDER_OVF_EN defined it also exposes the carry into its MSB.
module chunk_add #(
  parameter int unsigned CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
`ifdef CHUNKED_ADDER_OVF_EN
  ,
  output logic             cmsb
`endif
);

  logic [CHUNK:0] full;

  always_comb begin
    full = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
    s    = full[CHUNK-1:0];
    co   = full[CHUNK];
  end

`ifdef CHUNKED_ADDER_OVF_EN
  // The MSB sum bit is x^y^carry_in, so the carry into it falls out by XOR.
  always_comb begin
    cmsb = full[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];
  end
`endif

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: sum = a + b + cin, CHUNK bits per cycle, valid/ready on both sides.
// Optional signed-overflow output enabled by defining CHUNKED_ADDER_OVF_EN.
module chunked_serial_adder
  import chunked_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CHUNKED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("chunked_serial_adder: WIDTH must be a nonzero multiple of CHUNK");
  end

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;

  logic [CHUNK-1:0]  x_slice, y_slice, s_slice;
  logic              c_out;

`ifdef CHUNKED_ADDER_OVF_EN
  logic              ovf_q, ovf_d;
  logic              c_msb;
`endif

  always_comb begin
    x_slice = a_q[idx_q*CHUNK +: CHUNK];
    y_slice = b_q[idx_q*CHUNK +: CHUNK];
  end

  chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
    .x    (x_slice),
    .y    (y_slice),
    .ci   (carry_q),
    .s    (s_slice),
    .co   (c_out)
`ifdef CHUNKED_ADDER_OVF_EN
    ,
    .cmsb (c_msb)
`endif
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
`ifdef CHUNKED_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif
    in_ready  = (state_q == S_IDLE) && !rst;
    out_valid = (state_q == S_DONE);

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          sum_d   = '0;
          idx_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        sum_d[idx_q*CHUNK +: CHUNK] = s_slice;
        carry_d = c_out;
        if (idx_q == LAST_IDX) begin
          cout_d  = c_out;
`ifdef CHUNKED_ADDER_OVF_EN
          ovf_d   = c_out ^ c_msb;
`endif
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef CHUNKED_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    sum  = sum_q;
    cout = cout_q;
`ifdef CHUNKED_ADDER_OVF_EN
    ovf  = ovf_q;
`endif
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed self-checking bench for chunked_serial_adder (8/2, 4/1 and 4/4 instances).
module tb_chunked_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=8, CHUNK=2
  logic       rst, in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [7:0] a, b, sum;
  // WIDTH=4, CHUNK=1
  logic       in_valid_1, in_ready_1, cin_1, out_valid_1, cout_1;
  logic [3:0] a_1, b_1, sum_1;
  // WIDTH=4, CHUNK=4
  logic       in_valid_4, in_ready_4, cin_4, out_valid_4, cout_4;
  logic [3:0] a_4, b_4, sum_4;
`ifdef CHUNKED_ADDER_OVF_EN
  logic       ovf, ovf_1, ovf_4;
`endif

  chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef CHUNKED_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  chunked_serial_adder #(.WIDTH(4), .CHUNK(1)) dut_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .a(a_1), .b(b_1), .cin(cin_1), .out_valid(out_valid_1), .out_ready(1'b1),
    .sum(sum_1), .cout(cout_1)
`ifdef CHUNKED_ADDER_OVF_EN
    , .ovf(ovf_1)
`endif
  );

  chunked_serial_adder #(.WIDTH(4), .CHUNK(4)) dut_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_4), .in_ready(in_ready_4),
    .a(a_4), .b(b_4), .cin(cin_4), .out_valid(out_valid_4), .out_ready(1'b1),
    .sum(sum_4), .cout(cout_4)
`ifdef CHUNKED_ADDER_OVF_EN
    , .ovf(ovf_4)
`endif
  );

  // Present one operand set to the 8-bit DUT for a single accepting edge.
  task automatic issue8(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    @(negedge clk);
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Cycles from the first post-accept negedge until out_valid, capped at 20.
  task automatic wait_valid8(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; a = 8'hA5; b = 8'h5A; cin = 1'b1; out_ready = 1'b1;
    in_valid_1 = 1'b0; in_valid_4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: in_ready=%b out_valid=%b sum=%h cout=%b, required 0 0 00 0",
                 i, in_ready, out_valid, sum, cout);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_basic_add;
    int cyc;
    issue8(8'hFF, 8'h01, 1'b0);
    wait_valid8(cyc);
    checks++;
    if (cyc != 4 || sum !== 8'h00 || cout !== 1'b1) begin
      errors++;
      $display("FAIL basic_ff_01: latency=%0d sum=%h cout=%b, required 4 00 1", cyc, sum, cout);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_pop: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    issue8(8'h3C, 8'h42, 1'b1);
    wait_valid8(cyc);
    checks++;
    if (cyc != 4 || sum !== 8'h7F || cout !== 1'b0) begin
      errors++;
      $display("FAIL basic_3c_42_c1: latency=%0d sum=%h cout=%b, required 4 7f 0", cyc, sum, cout);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int cyc;
    out_ready = 1'b0;
    issue8(8'h12, 8'h34, 1'b0);
    wait_valid8(cyc);
    checks++;
    if (cyc != 4 || sum !== 8'h46 || cout !== 1'b0) begin
      errors++;
      $display("FAIL bp_result: latency=%0d sum=%h cout=%b, required 4 46 0", cyc, sum, cout);
    end
    a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 8'h46 || cout !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc%0d: out_valid=%b in_ready=%b sum=%h cout=%b, required 1 0 46 0",
                 i, out_valid, in_ready, sum, cout);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_next_accept: in_ready=%b, required 0", in_ready);
    end
    wait_valid8(cyc);
    checks++;
    if (cyc != 4 || sum !== 8'hFF || cout !== 1'b0) begin
      errors++;
      $display("FAIL bp_second: latency=%0d sum=%h cout=%b, required 4 ff 0", cyc, sum, cout);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int cyc;
    int seen;
    issue8(8'h77, 8'h11, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: out_valid=%b in_ready=%b sum=%h cout=%b, required 0 0 00 0",
               out_valid, in_ready, sum, cout);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_idle: in_ready=%b, required 1", in_ready);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrst_no_result: out_valid high %0d cycles, required 0", seen);
    end
    issue8(8'h10, 8'h20, 1'b0);
    wait_valid8(cyc);
    checks++;
    if (cyc != 4 || sum !== 8'h30 || cout !== 1'b0) begin
      errors++;
      $display("FAIL midrst_next: latency=%0d sum=%h cout=%b, required 4 30 0", cyc, sum, cout);
    end
    @(negedge clk);
  endtask

  task automatic test_exhaustive_c1;
    int cyc;
    logic [4:0] exp;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      a_1 = i[3:0]; b_1 = i[7:4]; cin_1 = i[8]; in_valid_1 = 1'b1;
      exp = {1'b0, a_1} + {1'b0, b_1} + {4'b0, cin_1};
      @(negedge clk);
      in_valid_1 = 1'b0;
      cyc = 0;
      while (!out_valid_1 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (cyc != 4 || {cout_1, sum_1} !== exp) begin
        errors++;
        $display("FAIL exh_c1 a=%h b=%h cin=%b: latency=%0d {cout,sum}=%h, required 4 %h",
                 a_1, b_1, cin_1, cyc, {cout_1, sum_1}, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_exhaustive_c4;
    int cyc;
    logic [4:0] exp;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      a_4 = i[3:0]; b_4 = i[7:4]; cin_4 = i[8]; in_valid_4 = 1'b1;
      exp = {1'b0, a_4} + {1'b0, b_4} + {4'b0, cin_4};
      @(negedge clk);
      in_valid_4 = 1'b0;
      cyc = 0;
      while (!out_valid_4 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (cyc != 1 || {cout_4, sum_4} !== exp) begin
        errors++;
        $display("FAIL exh_c4 a=%h b=%h cin=%b: latency=%0d {cout,sum}=%h, required 1 %h",
                 a_4, b_4, cin_4, cyc, {cout_4, sum_4}, exp);
      end
      @(negedge clk);
    end
  endtask

`ifdef CHUNKED_ADDER_OVF_EN
  task automatic test_overflow;
    int cyc;
    issue8(8'h7F, 8'h01, 1'b0);
    wait_valid8(cyc);
    checks++;
    if (sum !== 8'h80 || cout !== 1'b0 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_7f_01: sum=%h cout=%b ovf=%b, required 80 0 1", sum, cout, ovf);
    end
    @(negedge clk);
    issue8(8'h80, 8'hFF, 1'b0);
    wait_valid8(cyc);
    checks++;
    if (sum !== 8'h7F || cout !== 1'b1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_80_ff: sum=%h cout=%b ovf=%b, required 7f 1 1", sum, cout, ovf);
    end
    @(negedge clk);
    issue8(8'h01, 8'h01, 1'b0);
    wait_valid8(cyc);
    checks++;
    if (sum !== 8'h02 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_01_01: sum=%h cout=%b ovf=%b, required 02 0 0", sum, cout, ovf);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    in_valid_1 = 1'b0; a_1 = '0; b_1 = '0; cin_1 = 1'b0;
    in_valid_4 = 1'b0; a_4 = '0; b_4 = '0; cin_4 = 1'b0;
    test_reset();
    test_basic_add();
    test_backpressure();
    test_reset_mid();
    test_exhaustive_c1();
    test_exhaustive_c4();
`ifdef CHUNKED_ADDER_OVF_EN
    test_overflow();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
